// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key event generator.
//   EV_*        2-bit event codes carried on the event stream
//   key_state_e per-key FSM state encoding
//   cnt_width   counter width for the long/repeat timer
package key_event_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_LONG = 2'd2
    } key_state_e;

    // Width able to hold max(cl, cr) - 1; never narrower than one bit.
    function automatic int cnt_width(input int cl, input int cr);
        int m;
        m = (cl > cr) ? cl : cr;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_fsm.sv
// key_fsm: one key's press/release/long/repeat FSM with its hold timer.
//   clk, rst      clock, synchronous active-high reset
//   d_i           debounced key level (1 = pressed)
//   press_o ...   registered one-cycle event pulses
//   ev_o          next-cycle event strobe (same edge the pulse registers)
//   ev_code_o     code of that event
//
// state | meaning
// UP    | key released, waiting for press
// DOWN  | key held, counting towards the long-press threshold
// LONG  | long press reported, counting auto-repeat periods
module key_fsm
    import key_event_pkg::*;
#(
    parameter int CL = 5_000_000,
    parameter int CR = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_i,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic       ev_o,
    output logic [1:0] ev_code_o
);

    localparam int CW = cnt_width(CL, CR);
    localparam logic [CW-1:0] CL_TC = CW'(CL - 1);
    localparam logic [CW-1:0] CR_TC = CW'(CR - 1);

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_UP: begin
                if (d_i) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                // release is tested first so it beats a coincident terminal count
                if (!d_i) begin
                    release_d = 1'b1;
                    state_d   = ST_UP;
                end else if (cnt_q == CL_TC) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LONG;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LONG: begin
                if (!d_i) begin
                    release_d = 1'b1;
                    state_d   = ST_UP;
                end else if (cnt_q == CR_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

    // At most one of the *_d pulses is set in any cycle.
    assign ev_o      = press_d | release_d | long_d | repeat_d;
    assign ev_code_o = press_d   ? EV_PRESS   :
                       release_d ? EV_RELEASE :
                       long_d    ? EV_LONG    : EV_REPEAT;

endmodule

// File: rtl/key_event.sv
// key_event: per-key event pulses plus a merged one-deep event stream.
//   clk, rst        clock, synchronous active-high reset
//   d_i             debounced key levels
//   press_o/release_o/long_o/repeat_o  per-key one-cycle pulses
//   ev_valid/ev_ready/ev_key/ev_code   event stream (valid/ready)
//   ev_lost/lost_clr                   sticky drop flag and its clear
module key_event
    import key_event_pkg::*;
#(
    parameter int DW = 2,
    parameter int CL = 5_000_000,
    parameter int CR = 500_000,
    localparam int KW = (DW > 1) ? $clog2(DW) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] press_o,
    output logic [DW-1:0] release_o,
    output logic [DW-1:0] long_o,
    output logic [DW-1:0] repeat_o,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [KW-1:0] ev_key,
    output logic [1:0]    ev_code,
    output logic          ev_lost,
    input  logic          lost_clr
);

    logic [DW-1:0]      key_ev;
    logic [DW-1:0][1:0] key_code;

    for (genvar g = 0; g < DW; g++) begin : g_key
        key_fsm #(
            .CL(CL),
            .CR(CR)
        ) u_key_fsm (
            .clk       (clk),
            .rst       (rst),
            .d_i       (d_i[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .long_o    (long_o[g]),
            .repeat_o  (repeat_o[g]),
            .ev_o      (key_ev[g]),
            .ev_code_o (key_code[g])
        );
    end

    logic [DW-1:0]      pend_v_q, pend_v_d;
    logic [DW-1:0][1:0] pend_c_q, pend_c_d;
    logic               ev_valid_q, ev_valid_d;
    logic [KW-1:0]      ev_key_q, ev_key_d;
    logic [1:0]         ev_code_q, ev_code_d;
    logic               ev_lost_q, ev_lost_d;

    logic               load;
    logic               grant_vld;
    logic [KW-1:0]      grant_idx;
    logic               lost_now;

    // Fixed priority: scanning downwards leaves the lowest pending index.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (pend_v_q[i]) begin
                grant_vld = 1'b1;
                grant_idx = KW'(i);
            end
        end
    end

    assign load = !ev_valid_q || ev_ready;

    always_comb begin
        pend_v_d = pend_v_q;
        pend_c_d = pend_c_q;
        lost_now = 1'b0;
        for (int i = 0; i < DW; i++) begin
            // clear the transferred slot first so a same-cycle event can refill it
            if (load && grant_vld && (grant_idx == KW'(i))) begin
                pend_v_d[i] = 1'b0;
            end
            if (key_ev[i]) begin
                if (pend_v_d[i]) begin
                    lost_now = 1'b1;
                end else begin
                    pend_v_d[i] = 1'b1;
                    pend_c_d[i] = key_code[i];
                end
            end
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_key_d   = ev_key_q;
        ev_code_d  = ev_code_q;
        if (load) begin
            ev_valid_d = grant_vld;
            if (grant_vld) begin
                ev_key_d  = grant_idx;
                ev_code_d = pend_c_q[grant_idx];
            end
        end
        ev_lost_d = lost_now | (ev_lost_q & ~lost_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q   <= '0;
            pend_c_q   <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_code_q  <= '0;
            ev_lost_q  <= 1'b0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_c_q   <= pend_c_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_code_q  <= ev_code_d;
            ev_lost_q  <= ev_lost_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_key   = ev_key_q;
    assign ev_code  = ev_code_q;
    assign ev_lost  = ev_lost_q;

endmodule
